// File: rtl/qif_sched_pkg.sv
// Shared types and constants for the QIF neuron scheduler and its update core.
// Widths here are the defaults; the top derives its own index width from NUM_NEURONS.
package qif_sched_pkg;

  localparam int NUM_NEURONS_DEF = 4;
  localparam int IDX_W           = $clog2(NUM_NEURONS_DEF);
  localparam int SUM_W           = 10;
  localparam int V_W             = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef logic [IDX_W-1:0] evt_t;

endpackage

// File: rtl/qif_update_core.sv
// Combinational QIF step: V,B -> V_next and spike flag; zero latency, no flow control.
// Square is shifted down before the sum so the 10-bit sum never overflows for 8-bit V and B.
module qif_update_core
  import qif_sched_pkg::*;
#(
  parameter int THRESH   = 200,
  parameter int V_RESET  = 0,
  parameter int SQ_SHIFT = 8,
  parameter int LEAK     = 1
) (
  input  logic [V_W-1:0] v_i,
  input  logic [V_W-1:0] b_i,
  output logic [V_W-1:0] v_d_o,
  output logic           spike_o
);

  logic [2*V_W-1:0] sq_full;
  logic [SUM_W-1:0] sum_raw;
  logic [SUM_W-1:0] sum_leak;

  assign sq_full  = {{V_W{1'b0}}, v_i} * {{V_W{1'b0}}, v_i};
  assign sum_raw  = SUM_W'(v_i) + SUM_W'(sq_full >> SQ_SHIFT) + SUM_W'(b_i);

  // Leak floors at zero rather than wrapping.
  assign sum_leak = (sum_raw > SUM_W'(LEAK)) ? (sum_raw - SUM_W'(LEAK)) : '0;

  assign spike_o  = (sum_leak >= SUM_W'(THRESH));
  assign v_d_o    = spike_o ? V_W'(V_RESET) : sum_leak[V_W-1:0];

endmodule

// File: rtl/qif_neuron_scheduler.sv
// Sweeps one QIF core over NUM_NEURONS states, one neuron per cycle after each tick (N+1 busy cycles).
// Spikes go to a FIFO drained by valid/ready; a push into a full FIFO without a pop is dropped and flagged.
module qif_neuron_scheduler
  import qif_sched_pkg::*;
#(
  parameter int  NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int  THRESH      = 200,
  parameter int  V_RESET     = 0,
  parameter int  SQ_SHIFT    = 8,
  parameter int  LEAK        = 1,
  parameter int  FIFO_DEPTH  = 4,
  localparam int IW          = $clog2(NUM_NEURONS),
  localparam int AW          = $clog2(FIFO_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          tick_i,
  input  logic          cfg_we_i,
  input  logic [IW-1:0] cfg_addr_i,
  input  logic [7:0]    cfg_b_i,
  input  logic [IW-1:0] dbg_addr_i,
  output logic [7:0]    dbg_v_o,
  output logic          busy_o,
  output logic          sweep_done_o,
  output logic          tick_miss_o,
  output logic          evt_valid_o,
  output logic [IW-1:0] evt_idx_o,
  input  logic          evt_ready_i,
  output logic          evt_ovf_o,
  input  logic          ovf_clr_i
);

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic            busy_q;
  logic            done_q;
  logic            miss_q;

  logic [V_W-1:0]  v_q [NUM_NEURONS];
  logic [V_W-1:0]  b_q [NUM_NEURONS];

  logic [V_W-1:0]  v_d;
  logic            spike;
  logic            upd_en;

  logic [IW-1:0]   fifo_q [FIFO_DEPTH];
  logic [AW:0]     wr_q;
  logic [AW:0]     rd_q;
  logic            ovf_q;
  logic            ovf_d;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            push_ok;
  logic            drop;

  assign upd_en = (state_q == SWEEP);

  qif_update_core #(
    .THRESH   (THRESH),
    .V_RESET  (V_RESET),
    .SQ_SHIFT (SQ_SHIFT),
    .LEAK     (LEAK)
  ) u_core (
    .v_i     (v_q[ptr_q]),
    .b_i     (b_q[ptr_q]),
    .v_d_o   (v_d),
    .spike_o (spike)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      miss_q <= tick_i & busy_q;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tick_i) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          if (ptr_q == IW'(NUM_NEURONS - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_NEURONS; i++) v_q[i] <= V_W'(V_RESET);
    end else if (upd_en) begin
      v_q[ptr_q] <= v_d;
    end
  end

  // The core reads b_q before this edge, so a write to the neuron being updated lands for the next sweep.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_NEURONS; i++) b_q[i] <= '0;
    end else if (cfg_we_i) begin
      b_q[cfg_addr_i] <= cfg_b_i;
    end
  end

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push    = upd_en & spike;
  assign pop     = !empty & evt_ready_i;
  // A pop on the same edge frees the head slot, so a full FIFO can still take the push.
  assign push_ok = push & (!full | pop);
  assign drop    = push & full & !pop;
  assign ovf_d   = drop | (ovf_q & !ovf_clr_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo_q[wr_q[AW-1:0]] <= ptr_q;
        wr_q                 <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      ovf_q <= ovf_d;
    end
  end

  assign dbg_v_o      = v_q[dbg_addr_i];
  assign busy_o       = busy_q;
  assign sweep_done_o = done_q;
  assign tick_miss_o  = miss_q;
  assign evt_valid_o  = !empty;
  assign evt_idx_o    = fifo_q[rd_q[AW-1:0]];
  assign evt_ovf_o    = ovf_q;

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// Directed and random stimulus for qif_neuron_scheduler against a cycle-level behavioural model.
module tb_qif_neuron_scheduler;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int THR   = 200;
  localparam int SH    = 8;
  localparam int LK    = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_b;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_v;
  logic       busy;
  logic       sweep_done;
  logic       tick_miss;
  logic       evt_valid;
  logic [1:0] evt_idx;
  logic       evt_ready;
  logic       evt_ovf;
  logic       ovf_clr;

  int n_chk  = 0;
  int n_pass = 0;

  int mv [N];
  int mb [N];
  int mq [$];
  int m_phase;
  bit m_miss;
  bit m_ovf;

  qif_neuron_scheduler #(
    .NUM_NEURONS (N),
    .THRESH      (THR),
    .V_RESET     (0),
    .SQ_SHIFT    (SH),
    .LEAK        (LK),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .tick_i       (tick),
    .cfg_we_i     (cfg_we),
    .cfg_addr_i   (cfg_addr),
    .cfg_b_i      (cfg_b),
    .dbg_addr_i   (dbg_addr),
    .dbg_v_o      (dbg_v),
    .busy_o       (busy),
    .sweep_done_o (sweep_done),
    .tick_miss_o  (tick_miss),
    .evt_valid_o  (evt_valid),
    .evt_idx_o    (evt_idx),
    .evt_ready_i  (evt_ready),
    .evt_ovf_o    (evt_ovf),
    .ovf_clr_i    (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
  endtask

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0;
      mb[i] = 0;
    end
    mq.delete();
    m_phase = 0;
    m_miss  = 1'b0;
    m_ovf   = 1'b0;
  endfunction

  function automatic void m_update(input int v, input int b, output int vn, output bit spk);
    int s;
    s   = v + ((v * v) >> SH) + b;
    s   = (s > LK) ? s - LK : 0;
    spk = (s >= THR);
    vn  = spk ? 0 : s;
  endfunction

  // Phase 0 is idle, phase k in 1..N updates neuron k-1 at the coming edge, phase N+1 is the done cycle.
  function automatic void m_edge();
    bit pop;
    bit spk;
    bit drop;
    int upd;
    int vn;
    pop  = (mq.size() > 0) && evt_ready;
    spk  = 1'b0;
    drop = 1'b0;
    upd  = -1;
    vn   = 0;
    if (m_phase >= 1 && m_phase <= N) begin
      upd = m_phase - 1;
      m_update(mv[upd], mb[upd], vn, spk);
    end
    if (pop) void'(mq.pop_front());
    if (spk) begin
      if (mq.size() < DEPTH) mq.push_back(upd);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (upd >= 0) mv[upd] = vn;
    if (cfg_we) mb[cfg_addr] = cfg_b;
    m_miss = tick && (m_phase != 0);
    if (m_phase == 0) m_phase = tick ? 1 : 0;
    else if (m_phase == N + 1) m_phase = 0;
    else m_phase++;
  endfunction

  task automatic cmp_out();
    chk("busy", busy, int'(m_phase != 0));
    chk("sweep_done", sweep_done, int'(m_phase == N + 1));
    chk("tick_miss", tick_miss, int'(m_miss));
    chk("evt_valid", evt_valid, int'(mq.size() > 0));
    if (mq.size() > 0) chk("evt_idx", evt_idx, mq[0]);
    chk("evt_ovf", evt_ovf, int'(m_ovf));
    chk("dbg_v", dbg_v, mv[dbg_addr]);
  endtask

  task automatic cyc();
    m_edge();
    @(posedge clk);
    #1;
    cmp_out();
    tick    = 1'b0;
    cfg_we  = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic check_all_v(input string tag);
    for (int a = 0; a < N; a++) begin
      dbg_addr = 2'(a);
      #1;
      chk(tag, dbg_v, mv[a]);
    end
  endtask

  task automatic write_b(input int a, input int b);
    cfg_we   = 1'b1;
    cfg_addr = 2'(a);
    cfg_b    = 8'(b);
    cyc();
  endtask

  task automatic finish_sweep(output int nb, output int nd, output int nm, input int miss_at);
    nb = 0;
    nd = 0;
    nm = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      nb++;
      if (sweep_done) nd++;
      if (tick_miss) nm++;
      if (k == miss_at) tick = 1'b1;
      cyc();
    end
    if (tick_miss) nm++;
    chk("sweep_ends", busy, 0);
  endtask

  task automatic run_sweep(output int nb, output int nd, output int nm, input int miss_at);
    tick = 1'b1;
    cyc();
    finish_sweep(nb, nd, nm, miss_at);
  endtask

  initial begin
    int nb, nd, nm;
    int exp_v0 [3];
    exp_v0 = '{49, 107, 0};

    rst_n = 1'b0; tick = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_b = '0;
    dbg_addr = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmp_out();
    chk("rst_evt_idx", evt_idx, 0);

    // Idle after reset
    repeat (10) cyc();
    for (int a = 0; a < N; a++) begin
      dbg_addr = 2'(a);
      #1;
      chk("t1_v_zero", dbg_v, 0);
    end

    // Single driven neuron ramps then spikes on the third sweep
    write_b(0, 50);
    dbg_addr = 2'd0;
    for (int s = 0; s < 3; s++) begin
      chk("t2_no_evt_before", evt_valid, 0);
      run_sweep(nb, nd, nm, -1);
      chk("t2_busy_len", nb, N + 1);
      chk("t2_done_pulses", nd, 1);
      dbg_addr = 2'd0;
      #1;
      chk("t2_v0", dbg_v, exp_v0[s]);
    end
    chk("t2_evt_valid", evt_valid, 1);
    chk("t2_evt_idx", evt_idx, 0);
    evt_ready = 1'b1;
    cyc();
    evt_ready = 1'b0;
    chk("t2_evt_drained", evt_valid, 0);

    // No drive: leak keeps everything pinned at zero
    write_b(0, 0);
    repeat (5) run_sweep(nb, nd, nm, -1);
    for (int a = 0; a < N; a++) begin
      dbg_addr = 2'(a);
      #1;
      chk("t3_v_zero", dbg_v, 0);
    end
    chk("t3_no_evt", evt_valid, 0);

    // Saturating drive fills the FIFO, second sweep overflows
    for (int a = 0; a < N; a++) write_b(a, 255);
    run_sweep(nb, nd, nm, -1);
    chk("t4_ovf_after_fill", evt_ovf, 0);
    run_sweep(nb, nd, nm, -1);
    chk("t4_ovf_set", evt_ovf, 1);
    evt_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk("t4_pop_order", evt_idx, i);
      cyc();
    end
    evt_ready = 1'b0;
    chk("t4_empty", evt_valid, 0);
    ovf_clr = 1'b1;
    cyc();
    chk("t4_ovf_clr", evt_ovf, 0);

    // Tick while busy is ignored and flagged once
    run_sweep(nb, nd, nm, 1);
    chk("t5_busy_len", nb, N + 1);
    chk("t5_miss_pulses", nm, 1);
    check_all_v("t5_v");
    chk("t5_fifo_full_valid", evt_valid, 1);
    chk("t5_ovf_clean", evt_ovf, 0);
    // Full FIFO: pop and spike on the same edge
    tick = 1'b1;
    cyc();
    evt_ready = 1'b1;
    cyc();
    evt_ready = 1'b0;
    chk("t5_pushpop_ovf", evt_ovf, 0);
    chk("t5_pushpop_head", evt_idx, 1);
    finish_sweep(nb, nd, nm, -1);
    chk("t5_later_drop", evt_ovf, 1);
    evt_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk("t5_pop_order", evt_idx, (i + 1) % N);
      cyc();
    end
    evt_ready = 1'b0;
    ovf_clr = 1'b1;
    cyc();

    // Reset in the middle of a sweep
    write_b(1, 20);
    tick = 1'b1;
    cyc();
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    m_reset();
    cmp_out();
    chk("t6_rst_busy", busy, 0);
    check_all_v("t6_rst_v");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmp_out();

    // Config write on the update edge of that neuron
    write_b(1, 20);
    tick = 1'b1;
    cyc();
    cyc();
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_b = 8'd100;
    cyc();
    finish_sweep(nb, nd, nm, -1);
    dbg_addr = 2'd1;
    #1;
    chk("t6_old_b_used", dbg_v, 19);
    run_sweep(nb, nd, nm, -1);
    dbg_addr = 2'd1;
    #1;
    chk("t6_new_b_used", dbg_v, 119);

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      tick      = ($urandom_range(0, 7) == 0);
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_b     = 8'($urandom_range(0, 255));
      evt_ready = ($urandom_range(0, 3) == 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      dbg_addr  = 2'($urandom_range(0, 3));
      cyc();
    end
    check_all_v("rand_final_v");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
